batch_addr_sched: RTL and testbench

BATCH_ADDR_SCHED -- requirements
Module: batch_addr_sched

---
 rtl/batch_addr_sched.sv | 143 ++++++++++++++
 tb/tb_batch_addr_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/batch_addr_sched.sv
// Address scheduler for a four-segment sample RAM: one write stream plus forward and backward read streams.
// Optional macro BATCH_SCHED_SEGCNT_EN adds a 16-bit completed-segment counter output (seg_count).
module batch_addr_sched #(
   parameter  int DEPTH = 19,
   localparam int AW    = $clog2(4*DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          sample_write,
   output logic [AW-1:0] sample_addr_in,
   output logic [AW-1:0] sample_addr_out1,
   output logic [AW-1:0] sample_addr_out2,
   output logic [AW-1:0] sample_addr_out3,
   output logic          rd_valid_f,
   output logic          rd_valid_b,
   output logic          seg_start
`ifdef BATCH_SCHED_SEGCNT_EN
   ,
   output logic [15:0]   seg_count
`endif
);

   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {FILL0, FILL1, FILL2, RUN} state_e;

   state_e        state_q, state_d;
   logic [1:0]    wseg_q, wseg_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          write_q, write_d;
   logic [AW-1:0] addr_in_q, addr_in_d;
   logic [AW-1:0] addr_out1_q, addr_out1_d;
   logic [AW-1:0] addr_out2_q, addr_out2_d;
   logic [AW-1:0] addr_out3_q, addr_out3_d;
   logic          rd_valid_f_q, rd_valid_f_d;
   logic          rd_valid_b_q, rd_valid_b_d;
   logic          seg_start_q, seg_start_d;
   logic          seg_done;
   logic [AW-1:0] idx_fwd, idx_rev;
`ifdef BATCH_SCHED_SEGCNT_EN
   logic [15:0]   seg_count_q, seg_count_d;
`endif

   // Segment arithmetic is 2-bit, so (wseg - k) wraps mod 4 for free.
   function automatic logic [AW-1:0] seg_base(input logic [1:0] seg);
      return AW'(seg) * AW'(DEPTH);
   endfunction

   assign seg_done = (idx_q == IW'(DEPTH-1));
   assign idx_fwd  = AW'(idx_q);
   assign idx_rev  = AW'(DEPTH-1) - AW'(idx_q);

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d      = state_q;
      wseg_d       = wseg_q;
      idx_d        = idx_q;
      write_d      = 1'b0;
      addr_in_d    = addr_in_q;
      addr_out1_d  = addr_out1_q;
      addr_out2_d  = addr_out2_q;
      addr_out3_d  = addr_out3_q;
      rd_valid_f_d = 1'b0;
      rd_valid_b_d = 1'b0;
      seg_start_d  = 1'b0;
`ifdef BATCH_SCHED_SEGCNT_EN
      seg_count_d  = seg_count_q;
`endif
      if (in_valid) begin
         write_d      = 1'b1;
         addr_in_d    = seg_base(wseg_q)        + idx_fwd;
         addr_out1_d  = seg_base(wseg_q - 2'd1) + idx_fwd;
         addr_out2_d  = seg_base(wseg_q - 2'd2) + idx_rev;
         addr_out3_d  = seg_base(wseg_q - 2'd3) + idx_rev;
         rd_valid_f_d = (state_q != FILL0);
         rd_valid_b_d = (state_q == RUN);
         seg_start_d  = (idx_q == '0);
         if (seg_done) begin
            idx_d  = '0;
            wseg_d = wseg_q + 2'd1;
            case (state_q)
               FILL0:   state_d = FILL1;
               FILL1:   state_d = FILL2;
               default: state_d = RUN;
            endcase
`ifdef BATCH_SCHED_SEGCNT_EN
            seg_count_d = seg_count_q + 16'd1;
`endif
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
      if (rst) begin
         state_q      <= FILL0;
         wseg_q       <= '0;
         idx_q        <= '0;
         write_q      <= 1'b0;
         addr_in_q    <= '0;
         addr_out1_q  <= '0;
         addr_out2_q  <= '0;
         addr_out3_q  <= '0;
         rd_valid_f_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
         seg_start_q  <= 1'b0;
`ifdef BATCH_SCHED_SEGCNT_EN
         seg_count_q  <= '0;
`endif
      end else begin
         state_q      <= state_d;
         wseg_q       <= wseg_d;
         idx_q        <= idx_d;
         write_q      <= write_d;
         addr_in_q    <= addr_in_d;
         addr_out1_q  <= addr_out1_d;
         addr_out2_q  <= addr_out2_d;
         addr_out3_q  <= addr_out3_d;
         rd_valid_f_q <= rd_valid_f_d;
         rd_valid_b_q <= rd_valid_b_d;
         seg_start_q  <= seg_start_d;
`ifdef BATCH_SCHED_SEGCNT_EN
         seg_count_q  <= seg_count_d;
`endif
      end
   end

   assign sample_write     = write_q;
   assign sample_addr_in   = addr_in_q;
   assign sample_addr_out1 = addr_out1_q;
   assign sample_addr_out2 = addr_out2_q;
   assign sample_addr_out3 = addr_out3_q;
   assign rd_valid_f       = rd_valid_f_q;
   assign rd_valid_b       = rd_valid_b_q;
   assign seg_start        = seg_start_q;
`ifdef BATCH_SCHED_SEGCNT_EN
   assign seg_count        = seg_count_q;
`endif

endmodule

// File: tb/tb_batch_addr_sched.sv
// Bench for batch_addr_sched (DEPTH=4): outputs are compared against a model driven by the count of valids since reset.
module tb_batch_addr_sched;

   localparam int D  = 4;
   localparam int AW = $clog2(4*D);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          sample_write;
   logic [AW-1:0] sample_addr_in;
   logic [AW-1:0] sample_addr_out1;
   logic [AW-1:0] sample_addr_out2;
   logic [AW-1:0] sample_addr_out3;
   logic          rd_valid_f;
   logic          rd_valid_b;
   logic          seg_start;
`ifdef BATCH_SCHED_SEGCNT_EN
   logic [15:0]   seg_count;
`endif

   batch_addr_sched #(.DEPTH(D)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .sample_write     (sample_write),
      .sample_addr_in   (sample_addr_in),
      .sample_addr_out1 (sample_addr_out1),
      .sample_addr_out2 (sample_addr_out2),
      .sample_addr_out3 (sample_addr_out3),
      .rd_valid_f       (rd_valid_f),
      .rd_valid_b       (rd_valid_b),
      .seg_start        (seg_start)
`ifdef BATCH_SCHED_SEGCNT_EN
      ,
      .seg_count        (seg_count)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int n     = 0;   // valids accepted since the last reset
   int wr_seen;
   int valid_sent;
   int exp_in, exp_o1, exp_o2, exp_o3;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: the k-th valid after reset lands in segment k/D (mod 4) at word k%D.
   task automatic step(input logic v);
      int seg, idx, done;
      done     = 0;
      idx      = 0;
      rst      = 1'b0;
      in_valid = v;
      @(posedge clk);
      #1;
      if (v) begin
         seg    = (n / D) % 4;
         idx    = n % D;
         done   = n / D;
         exp_in = seg * D + idx;
         exp_o1 = ((seg + 3) % 4) * D + idx;
         exp_o2 = ((seg + 2) % 4) * D + (D - 1 - idx);
         exp_o3 = ((seg + 1) % 4) * D + (D - 1 - idx);
         n++;
      end
      if (sample_write === 1'b1) wr_seen++;
      check("sample_write", 32'(sample_write), 32'(v));
      check("addr_in",      32'(sample_addr_in),   32'(exp_in));
      check("addr_out1",    32'(sample_addr_out1), 32'(exp_o1));
      check("addr_out2",    32'(sample_addr_out2), 32'(exp_o2));
      check("addr_out3",    32'(sample_addr_out3), 32'(exp_o3));
      check("rd_valid_f",   32'(rd_valid_f), 32'(v && done >= 1));
      check("rd_valid_b",   32'(rd_valid_b), 32'(v && done >= 3));
      check("seg_start",    32'(seg_start),  32'(v && idx == 0));
`ifdef BATCH_SCHED_SEGCNT_EN
      check("seg_count",    32'(seg_count),  32'(n / D));
`endif
   endtask

   // in_valid is held high through reset to confirm reset wins.
   task automatic do_reset(input int cycles);
      rst      = 1'b1;
      in_valid = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      n      = 0;
      exp_in = 0;
      exp_o1 = 0;
      exp_o2 = 0;
      exp_o3 = 0;
      check("rst_write",  32'(sample_write),     32'd0);
      check("rst_in",     32'(sample_addr_in),   32'd0);
      check("rst_out1",   32'(sample_addr_out1), 32'd0);
      check("rst_out2",   32'(sample_addr_out2), 32'd0);
      check("rst_out3",   32'(sample_addr_out3), 32'd0);
      check("rst_rd_f",   32'(rd_valid_f),       32'd0);
      check("rst_rd_b",   32'(rd_valid_b),       32'd0);
      check("rst_start",  32'(seg_start),        32'd0);
`ifdef BATCH_SCHED_SEGCNT_EN
      check("rst_segcnt", 32'(seg_count),        32'd0);
`endif
      rst      = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;

      do_reset(2);

      // Gapless: fill, enter RUN and wrap the write segment back to 0.
      for (int i = 0; i < 20; i++) step(1'b1);
      check("valids_after_20", 32'(n), 32'd20);

      // Idle cycles must not move anything.
      repeat (3) step(1'b0);

      // Random gaps between valids.
      wr_seen    = 0;
      valid_sent = 0;
      for (int i = 0; i < 40; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) step(1'b0);
         step(1'b1);
         valid_sent++;
      end
      check("write_count", 32'(wr_seen), 32'(valid_sent));

      // Reset mid-segment after valid 6, then a single valid.
      do_reset(1);
      for (int i = 0; i < 6; i++) step(1'b1);
      do_reset(1);
      step(1'b1);
      check("post_rst_addr", 32'(sample_addr_in), 32'd0);
      check("post_rst_rdf",  32'(rd_valid_f),     32'd0);

      // Random reset points followed by a run long enough to reach RUN.
      for (int r = 0; r < 3; r++) begin
         int pre;
         pre = $urandom_range(1, 15);
         for (int i = 0; i < pre; i++) step($urandom_range(0, 1) == 1);
         do_reset(1);
         for (int i = 0; i < 18; i++) step($urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
